program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder of the instruction fetch stage: receives the program as a byte stream from the UART receiver and drives the instruction memory's byte-write port.
- Counts bytes and assembles them into 32-bit words to detect the HALT instruction.
- Pulses a PC reset at load start and flags completion or overflow to the debug unit.
- While the block is not in LOAD, fetch owns the memory and the write enable is low.

Parameters:
- NB_DATA, 32, instruction width in bits.
- NB_BYTE, 8, width of a UART byte and of the memory write port.
- NB_INSTRUCTION_ADDRESS, 7, byte-address width of instruction memory; capacity = 2^NB_INSTRUCTION_ADDRESS bytes.
- HALT_INSTRUCTION, 32'hFFFFFFFF, word that terminates the program.

Ports:
- i_clock  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_start_load  input  1  one-cycle request to begin a load
- i_rx_data  input  NB_BYTE  received UART byte
- i_rx_valid  input  1  one-cycle strobe; i_rx_data valid this cycle
- o_load_program_byte  output  NB_BYTE  byte to instruction memory
- o_load_program_write_enable  output  1  memory byte-write strobe
- o_pc_reset  output  1  one-cycle PC clear to fetch
- o_loading  output  1  high while in LOAD
- o_load_done  output  1  level; program ended with HALT
- o_load_error  output  1  level; memory filled without HALT
- o_instruction_count  output  NB_INSTRUCTION_ADDRESS-1  complete words written, HALT included

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Byte counter 0, word shift register 0.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE:
  - i_rx_valid is ignored.
  - On i_start_load, go to LOAD, clear the counter, word register, o_load_done and o_load_error, and assert o_pc_reset for exactly the next cycle.
- LOAD:
  - o_loading = 1.
  - For each cycle N with i_rx_valid = 1:
    - In cycle N+1, o_load_program_write_enable = 1 and o_load_program_byte = the byte captured at N.
    - Otherwise write enable is 0; o_load_program_byte holds its last value.
  - Byte counter increments on each accepted byte. The memory advances its own write pointer on each write enable, so the block does not drive an address.
  - Word register shifts big-endian: word <= {word[23:0], i_rx_data}. The first byte of each group of 4 is the MSB.
  - On accepting the 4th byte of a group, o_instruction_count increments in cycle N+1.
  - HALT detection: when the 4th byte of a group completes a word equal to HALT_INSTRUCTION, go to DONE. That byte is still written, in cycle N+1.
  - Overflow: if the accepted byte is the last address (count = 2^NB_INSTRUCTION_ADDRESS - 1) and no HALT was detected, write it, then go to ERROR. No further writes occur.
  - i_start_load during LOAD is ignored (no restart, no o_pc_reset).
  - HALT takes priority when HALT completes exactly on the last address.
- DONE:
  - o_load_done = 1 (level), o_loading = 0.
  - Bytes are ignored.
  - i_start_load restarts as from IDLE.
- ERROR:
  - o_load_error = 1 (level), o_loading = 0.
  - Bytes are ignored.
  - i_start_load restarts as from IDLE.
- Latency: byte strobe to memory write = 1 cycle; HALT byte strobe to o_load_done = 1 cycle.
- o_pc_reset and o_load_program_write_enable are never asserted in the same cycle.
- i_reset mid-load:
  - Next cycle is IDLE with all outputs 0.
  - Any pending registered write is dropped; write enable is 0.
- Back-to-back i_rx_valid on consecutive cycles is supported, with one write per cycle.

Test Plan:
- Reset then idle bytes:
  - i_reset = 1 for 2 cycles, then i_rx_valid pulses with 0xAA while in IDLE.
  - Required: all outputs 0, no write strobes.
- Normal load:
  - Start, then bytes 0x20,0x01,0x00,0x05, FF,FF,FF,FF with gaps.
  - Required: o_pc_reset one cycle after start.
  - Required: 8 write strobes, each 1 cycle after its rx_valid, carrying those bytes in order.
  - Required: o_load_done = 1 one cycle after the last byte; o_instruction_count = 2.
- Back-to-back bytes:
  - 8 consecutive-cycle rx_valid pulses ending in HALT.
  - Required: 8 consecutive write strobes; done after the 8th.
- Non-aligned 0xFF:
  - Bytes 0x00,0xFF,0xFF,0xFF, 0xFF,0x00,0x00,0x00.
  - Required: no done, count = 2, still LOAD.
- Overflow:
  - 128 non-HALT bytes.
  - Required: 128 writes, then o_load_error = 1; a 129th byte produces no write.
  - Restart with i_start_load: error clears, o_pc_reset pulses, counter is 0.
- Reset mid-load:
  - After 5 bytes, assert i_reset for the cycle where a write is pending.
  - Required: write enable 0 next cycle, state IDLE, o_instruction_count = 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
// Receives the program as a UART byte stream and forwards each byte to the
// instruction memory's byte-write port. Bytes are grouped into big-endian
// 32-bit words so the HALT instruction can end the load. A PC clear is pulsed
// when a load starts. Completion (HALT seen) and overflow (memory filled
// without HALT) are reported as levels to the debug unit. Outside LOAD the
// write enable stays low so the fetch stage owns the memory.

module program_loader #(
    parameter int                NB_DATA                = 32,
    parameter int                NB_BYTE                = 8,
    parameter int                NB_INSTRUCTION_ADDRESS = 7,
    parameter logic [NB_DATA-1:0] HALT_INSTRUCTION      = 32'hFFFFFFFF
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_start_load,
    input  logic [NB_BYTE-1:0]                i_rx_data,
    input  logic                              i_rx_valid,
    output logic [NB_BYTE-1:0]                o_load_program_byte,
    output logic                              o_load_program_write_enable,
    output logic                              o_pc_reset,
    output logic                              o_loading,
    output logic                              o_load_done,
    output logic                              o_load_error,
    output logic [NB_INSTRUCTION_ADDRESS-2:0] o_instruction_count
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BYTE_SEL    = $clog2(BYTES_PER_WORD);
    // Only the three most recent bytes need to be kept: the fourth one is
    // the incoming byte itself when the word is checked against HALT.
    localparam int NB_WORD_HISTORY = NB_DATA - NB_BYTE;

    localparam logic [NB_INSTRUCTION_ADDRESS-1:0] LAST_ADDRESS =
        {NB_INSTRUCTION_ADDRESS{1'b1}};
    localparam logic [NB_BYTE_SEL-1:0] LAST_BYTE_OF_WORD =
        NB_BYTE_SEL'(BYTES_PER_WORD - 1);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_LOAD  = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;
    localparam logic [1:0] STATE_ERROR = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [NB_INSTRUCTION_ADDRESS-1:0] byte_count;
    logic [NB_WORD_HISTORY-1:0]        word_history;
    logic [NB_DATA-1:0]                assembled_word;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic start_accepted;
    logic byte_accepted;
    logic word_complete;
    logic halt_detected;
    logic last_address_reached;

    // A start request is honoured from every state except LOAD.
    assign start_accepted = i_start_load && (state != STATE_LOAD);

    // Bytes only matter while loading; IDLE/DONE/ERROR drop them.
    assign byte_accepted = i_rx_valid && (state == STATE_LOAD);

    // The fourth byte of each group closes a word.
    assign word_complete = byte_accepted &&
                           (byte_count[NB_BYTE_SEL-1:0] == LAST_BYTE_OF_WORD);

    // Big-endian: earlier bytes are more significant.
    assign assembled_word = {word_history, i_rx_data};

    assign halt_detected = word_complete && (assembled_word == HALT_INSTRUCTION);

    assign last_address_reached = byte_accepted && (byte_count == LAST_ADDRESS);

    // Next-state selection; HALT wins over overflow on the last address.
    always_comb begin
        // NOTE: default assignment first so every path drives next_state and no latch is inferred.
        next_state = state;
        case (state)
            STATE_IDLE: begin
                if (start_accepted) begin
                    next_state = STATE_LOAD;
                end
            end
            STATE_LOAD: begin
                if (halt_detected) begin
                    next_state = STATE_DONE;
                end else if (last_address_reached) begin
                    next_state = STATE_ERROR;
                end
            end
            STATE_DONE, STATE_ERROR: begin
                if (start_accepted) begin
                    next_state = STATE_LOAD;
                end
            end
            default: begin
                next_state = STATE_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clock) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Byte counter and word history: cleared on start, advanced per accepted byte.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            byte_count   <= '0;
            word_history <= '0;
        end else if (start_accepted) begin
            byte_count   <= '0;
            word_history <= '0;
        end else if (byte_accepted) begin
            byte_count   <= byte_count + 1'b1;
            word_history <= assembled_word[NB_WORD_HISTORY-1:0];
        end
    end

    // Completed-word counter, HALT word included.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_instruction_count <= '0;
        end else if (start_accepted) begin
            o_instruction_count <= '0;
        end else if (word_complete) begin
            o_instruction_count <= o_instruction_count + 1'b1;
        end
    end

    // PC clear is high for exactly the cycle after an accepted start.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_pc_reset <= 1'b0;
        end else begin
            o_pc_reset <= start_accepted;
        end
    end

    // Registered memory write: strobe one cycle after each accepted byte,
    // the byte itself holds its value between writes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_load_program_write_enable <= 1'b0;
            o_load_program_byte         <= '0;
        end else begin
            o_load_program_write_enable <= byte_accepted;
            if (byte_accepted) begin
                o_load_program_byte <= i_rx_data;
            end
        end
    end

    // Status levels decoded straight from the state register.
    assign o_loading    = (state == STATE_LOAD);
    assign o_load_done  = (state == STATE_DONE);
    assign o_load_error = (state == STATE_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, so what is observed is
// the registered result of the previous cycle.

module tb_program_loader;

    logic       i_clock;
    logic       i_reset;
    logic       i_start_load;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_load_program_byte;
    logic       o_load_program_write_enable;
    logic       o_pc_reset;
    logic       o_loading;
    logic       o_load_done;
    logic       o_load_error;
    logic [5:0] o_instruction_count;

    int vectors;
    int miscompares;

    program_loader dut (
        .i_clock                     (i_clock),
        .i_reset                     (i_reset),
        .i_start_load                (i_start_load),
        .i_rx_data                   (i_rx_data),
        .i_rx_valid                  (i_rx_valid),
        .o_load_program_byte         (o_load_program_byte),
        .o_load_program_write_enable (o_load_program_write_enable),
        .o_pc_reset                  (o_pc_reset),
        .o_loading                   (o_loading),
        .o_load_done                 (o_load_done),
        .o_load_error                (o_load_error),
        .o_instruction_count         (o_instruction_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // PC clear and memory write must never coincide.
    always @(negedge i_clock) begin
        vectors++;
        if (o_pc_reset === 1'b1 && o_load_program_write_enable === 1'b1) begin
            miscompares++;
            $display("FAIL pc_reset_write_overlap: pc_reset=%b we=%b required not both 1 at %0t",
                     o_pc_reset, o_load_program_write_enable, $time);
        end
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Issue a one-cycle start request; afterwards the PC-clear cycle is visible.
    task automatic pulse_start();
        i_start_load = 1'b1;
        step();
        i_start_load = 1'b0;
    endtask

    task automatic test_reset();
        i_reset      = 1'b1;
        i_start_load = 1'b0;
        i_rx_valid   = 1'b0;
        i_rx_data    = 8'h00;
        step();
        step();
        i_reset = 1'b0;
        vectors++;
        if ({o_load_program_byte, o_load_program_write_enable, o_pc_reset, o_loading,
             o_load_done, o_load_error, o_instruction_count} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: byte=%h we=%b pcr=%b ld=%b dn=%b er=%b cnt=%0d required all 0",
                     o_load_program_byte, o_load_program_write_enable, o_pc_reset, o_loading,
                     o_load_done, o_load_error, o_instruction_count);
        end
        for (int i = 0; i < 3; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'hAA;
            step();
            i_rx_valid = 1'b0;
            vectors++;
            if (o_load_program_write_enable !== 1'b0 || o_loading !== 1'b0 ||
                o_load_program_byte !== 8'h00) begin
                miscompares++;
                $display("FAIL idle_byte_ignored: we=%b loading=%b byte=%h required 0/0/00",
                         o_load_program_write_enable, o_loading, o_load_program_byte);
            end
            step();
        end
    endtask

    task automatic test_normal_load();
        logic [7:0] bytes [8];
        bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        vectors++;
        if (o_pc_reset !== 1'b1 || o_loading !== 1'b1) begin
            miscompares++;
            $display("FAIL normal_pc_reset: pcr=%b loading=%b required 1/1", o_pc_reset, o_loading);
        end
        step();
        vectors++;
        if (o_pc_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_pc_reset_width: pcr=%b required 0", o_pc_reset);
        end
        for (int i = 0; i < 8; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = bytes[i];
            step();
            i_rx_valid = 1'b0;
            i_rx_data  = 8'h5A;
            vectors++;
            if (o_load_program_write_enable !== 1'b1 || o_load_program_byte !== bytes[i]) begin
                miscompares++;
                $display("FAIL normal_write[%0d]: we=%b byte=%h required 1/%h",
                         i, o_load_program_write_enable, o_load_program_byte, bytes[i]);
            end
            if (i == 3) begin
                vectors++;
                if (o_instruction_count !== 6'd1) begin
                    miscompares++;
                    $display("FAIL normal_count_first_word: count=%0d required 1", o_instruction_count);
                end
            end
            if (i < 7) begin
                vectors++;
                if (o_load_done !== 1'b0 || o_loading !== 1'b1) begin
                    miscompares++;
                    $display("FAIL normal_early_done[%0d]: done=%b loading=%b required 0/1",
                             i, o_load_done, o_loading);
                end
                step();
                vectors++;
                if (o_load_program_write_enable !== 1'b0 || o_load_program_byte !== bytes[i]) begin
                    miscompares++;
                    $display("FAIL normal_gap[%0d]: we=%b byte=%h required 0/%h",
                             i, o_load_program_write_enable, o_load_program_byte, bytes[i]);
                end
            end
        end
        vectors++;
        if (o_load_done !== 1'b1 || o_loading !== 1'b0 || o_instruction_count !== 6'd2 ||
            o_load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_done: done=%b loading=%b count=%0d error=%b required 1/0/2/0",
                     o_load_done, o_loading, o_instruction_count, o_load_error);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h33;
        step();
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_program_write_enable !== 1'b0 || o_load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_byte_ignored: we=%b done=%b required 0/1",
                     o_load_program_write_enable, o_load_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        vectors++;
        if (o_pc_reset !== 1'b1 || o_load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_restart: pcr=%b done=%b required 1/0", o_pc_reset, o_load_done);
        end
        // First byte arrives during the PC-clear cycle.
        for (int i = 0; i < 8; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = bytes[i];
            step();
            vectors++;
            if (o_load_program_write_enable !== 1'b1 || o_load_program_byte !== bytes[i]) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: we=%b byte=%h required 1/%h",
                         i, o_load_program_write_enable, o_load_program_byte, bytes[i]);
            end
        end
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_done !== 1'b1 || o_instruction_count !== 6'd2) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b count=%0d required 1/2", o_load_done, o_instruction_count);
        end
        step();
        vectors++;
        if (o_load_program_write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after: we=%b required 0", o_load_program_write_enable);
        end
    endtask

    task automatic test_nonaligned_ff();
        logic [7:0] bytes [8];
        bytes = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        pulse_start();
        step();
        for (int i = 0; i < 8; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = bytes[i];
            step();
            vectors++;
            if (o_load_program_write_enable !== 1'b1 || o_load_program_byte !== bytes[i]) begin
                miscompares++;
                $display("FAIL nonaligned_write[%0d]: we=%b byte=%h required 1/%h",
                         i, o_load_program_write_enable, o_load_program_byte, bytes[i]);
            end
        end
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_done !== 1'b0 || o_loading !== 1'b1 || o_instruction_count !== 6'd2) begin
            miscompares++;
            $display("FAIL nonaligned_state: done=%b loading=%b count=%0d required 0/1/2",
                     o_load_done, o_loading, o_instruction_count);
        end
    endtask

    task automatic test_overflow();
        // The load from the previous test is still running; LOAD ignores start.
        pulse_start();
        vectors++;
        if (o_pc_reset !== 1'b0 || o_instruction_count !== 6'd2) begin
            miscompares++;
            $display("FAIL load_ignores_start: pcr=%b count=%0d required 0/2",
                     o_pc_reset, o_instruction_count);
        end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        pulse_start();
        step();
        for (int i = 0; i < 128; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'(i);
            step();
            vectors++;
            if (o_load_program_write_enable !== 1'b1 || o_load_program_byte !== 8'(i)) begin
                miscompares++;
                $display("FAIL overflow_write[%0d]: we=%b byte=%h required 1/%h",
                         i, o_load_program_write_enable, o_load_program_byte, 8'(i));
            end
            if (i == 126) begin
                vectors++;
                if (o_load_error !== 1'b0 || o_loading !== 1'b1) begin
                    miscompares++;
                    $display("FAIL overflow_early: error=%b loading=%b required 0/1",
                             o_load_error, o_loading);
                end
            end
        end
        i_rx_data = 8'h77;
        vectors++;
        if (o_load_error !== 1'b1 || o_loading !== 1'b0 || o_load_done !== 1'b0 ||
            o_instruction_count !== 6'd32) begin
            miscompares++;
            $display("FAIL overflow_error: error=%b loading=%b done=%b count=%0d required 1/0/0/32",
                     o_load_error, o_loading, o_load_done, o_instruction_count);
        end
        step();
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_program_write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_129th: we=%b required 0", o_load_program_write_enable);
        end
        pulse_start();
        vectors++;
        if (o_load_error !== 1'b0 || o_pc_reset !== 1'b1 || o_loading !== 1'b1 ||
            o_instruction_count !== 6'd0) begin
            miscompares++;
            $display("FAIL overflow_restart: error=%b pcr=%b loading=%b count=%0d required 0/1/1/0",
                     o_load_error, o_pc_reset, o_loading, o_instruction_count);
        end
        // A fresh HALT word must be recognised, proving the byte counter restarted at 0.
        for (int i = 0; i < 4; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'hFF;
            step();
        end
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_done !== 1'b1 || o_instruction_count !== 6'd1) begin
            miscompares++;
            $display("FAIL overflow_restart_halt: done=%b count=%0d required 1/1",
                     o_load_done, o_instruction_count);
        end
    endtask

    task automatic test_halt_on_last();
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = (i >= 124) ? 8'hFF : 8'h01;
            step();
        end
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_done !== 1'b1 || o_load_error !== 1'b0 || o_instruction_count !== 6'd32 ||
            o_load_program_write_enable !== 1'b1 || o_load_program_byte !== 8'hFF) begin
            miscompares++;
            $display("FAIL halt_on_last: done=%b error=%b count=%0d we=%b byte=%h required 1/0/32/1/ff",
                     o_load_done, o_load_error, o_instruction_count,
                     o_load_program_write_enable, o_load_program_byte);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'(i);
            step();
        end
        vectors++;
        if (o_instruction_count !== 6'd1 || o_load_program_write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: count=%0d we=%b required 1/1",
                     o_instruction_count, o_load_program_write_enable);
        end
        // Fifth byte arrives together with reset: its write must be dropped.
        i_rx_data = 8'h05;
        i_reset   = 1'b1;
        step();
        i_reset    = 1'b0;
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_program_write_enable !== 1'b0 || o_loading !== 1'b0 ||
            o_instruction_count !== 6'd0 || o_load_program_byte !== 8'h00 ||
            o_load_done !== 1'b0 || o_load_error !== 1'b0 || o_pc_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: we=%b loading=%b count=%0d byte=%h done=%b err=%b pcr=%b required all 0",
                     o_load_program_write_enable, o_loading, o_instruction_count,
                     o_load_program_byte, o_load_done, o_load_error, o_pc_reset);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h66;
        step();
        i_rx_valid = 1'b0;
        vectors++;
        if (o_load_program_write_enable !== 1'b0 || o_loading !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle: we=%b loading=%b required 0/0",
                     o_load_program_write_enable, o_loading);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_normal_load();
        test_back_to_back();
        test_nonaligned_ff();
        test_overflow();
        test_halt_on_last();
        test_reset_mid_load();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
